// File: rtl/nmcu_pkg.sv
// -----------------------------------------------------------------------------
// nmcu_pkg
//   Shared types for the NMCU memory path.
//   - mem_req_t / mem_resp_t : request and response to/from the cache system
//   - arb_state_t            : state of the memory request arbiter
//   - MEM_ARB_MAX_REQ        : largest number of requesters the arbiter supports
//   - wrap_inc()             : modulo-n increment used for round-robin pointers
// -----------------------------------------------------------------------------
package nmcu_pkg;

    localparam int MEM_ADDR_W      = 32;
    localparam int MEM_DATA_W      = 32;
    localparam int MEM_ARB_MAX_REQ = 8;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [3:0]            be;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [MEM_DATA_W-1:0] rdata;
        logic                  err;
    } mem_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Purely combinational round-robin search: returns the first set bit of
//   pending_i at or after rr_ptr_i, wrapping modulo NUM_REQ.
//   Ports:
//     pending_i [NUM_REQ]  one bit per requester with a pending slot
//     rr_ptr_i  [ID_WIDTH] search start index (always < NUM_REQ)
//     found_o              at least one pending bit is set
//     idx_o     [ID_WIDTH] winning index (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]  pending_i,
    input  logic [ID_WIDTH-1:0] rr_ptr_i,
    output logic                found_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int                  sum;
            logic [ID_WIDTH-1:0] cand;
            sum = int'(rr_ptr_i) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = ID_WIDTH'(sum);
            // First hit in search order wins; later hits are ignored.
            if (!found_o && pending_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//   Shares the single cache-system port between NUM_REQ requesters (decoder,
//   prefetch engine, debug/DMA). Each requester pulse is parked in a private
//   slot, slots are granted round-robin, exactly one transaction is in flight
//   downstream, and the cache response is routed back to its owner only.
//
//   Handshake: req_i[k].valid is a one-cycle pulse with no ready. A pulse is
//   accepted when slot k is empty and k does not own the in-flight
//   transaction; otherwise it is dropped and err_o is set (sticky until
//   reset). cache_req_o.valid is a one-cycle pulse (ARB_ISSUE). The first
//   cache_resp_i.valid seen in ARB_WAIT completes the transaction and is
//   forwarded the same cycle; responses in any other state are ignored.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     req_i[NUM_REQ]    per-requester request pulse + payload
//     resp_o[NUM_REQ]   per-requester response (only the owner's is non-zero)
//     cache_req_o       request to cache system (all-zero outside ARB_ISSUE)
//     cache_resp_i      response from cache system
//     busy_o            transaction in flight (state != ARB_IDLE)
//     grant_id_o        current or last owner index
//     err_o             sticky protocol-violation flag
//     dbg_state_o       arbiter FSM state
//   Optional (`define MEM_ARB_STATS_EN):
//     grant_cnt_o[NUM_REQ]  saturating count of issues per requester
//     wait_cyc_o[NUM_REQ]   saturating count of cycles pending but not owner
//     stats_clr_i           synchronous clear of both counter sets
// -----------------------------------------------------------------------------
module mem_req_arbiter
    import nmcu_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  mem_req_t            req_i        [NUM_REQ],
    output mem_resp_t           resp_o       [NUM_REQ],
    output mem_req_t            cache_req_o,
    input  mem_resp_t           cache_resp_i,
    output logic                busy_o,
    output logic [ID_WIDTH-1:0] grant_id_o,
    output logic                err_o,
    output arb_state_t          dbg_state_o
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]         grant_cnt_o  [NUM_REQ],
    output logic [31:0]         wait_cyc_o   [NUM_REQ],
    input  logic                stats_clr_i
`endif
);

    arb_state_t          state_q,   state_d;
    logic [ID_WIDTH-1:0] owner_q,   owner_d;
    logic [ID_WIDTH-1:0] rr_ptr_q,  rr_ptr_d;
    logic                err_q,     err_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    mem_req_t            slot_q     [NUM_REQ];
    mem_req_t            slot_d     [NUM_REQ];

    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                owner_active;

    // The owner register keeps its value in ARB_IDLE, so ownership only
    // blocks a requester while a transaction is actually in flight.
    assign owner_active = (state_q != ARB_IDLE);

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .found_o   (pick_found),
        .idx_o     (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        err_d       = err_q;
        pending_d   = pending_q;
        cache_req_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot_d[k] = slot_q[k];
            resp_o[k] = '0;
        end

        // Capture. An accepted slot is frozen until its release, so later
        // req_i activity cannot disturb it.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_i[k].valid) begin
                if (!pending_q[k] &&
                    !(owner_active && (owner_q == ID_WIDTH'(k)))) begin
                    pending_d[k] = 1'b1;
                    slot_d[k]    = req_i[k];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (owner_q == ID_WIDTH'(k)) begin
                        cache_req_o = slot_q[k];
                    end
                end
                cache_req_o.valid = 1'b1;
                state_d           = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cache_resp_i.valid) begin
                    // Zero-latency return path to the owner; release its slot
                    // and start the next search just past it.
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (owner_q == ID_WIDTH'(k)) begin
                            resp_o[k]    = cache_resp_i;
                            pending_d[k] = 1'b0;
                        end
                    end
                    rr_ptr_d = ID_WIDTH'(wrap_inc(int'(owner_q), NUM_REQ));
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
            pending_q <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    assign busy_o      = owner_active;
    assign grant_id_o  = owner_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];
    logic [31:0] wait_cyc_q  [NUM_REQ];
    logic [31:0] wait_cyc_d  [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt_d[k] = grant_cnt_q[k];
            wait_cyc_d[k]  = wait_cyc_q[k];
            if (stats_clr_i) begin
                grant_cnt_d[k] = '0;
                wait_cyc_d[k]  = '0;
            end else begin
                if ((state_q == ARB_ISSUE) && (owner_q == ID_WIDTH'(k)) &&
                    (grant_cnt_q[k] != '1)) begin
                    grant_cnt_d[k] = grant_cnt_q[k] + 32'd1;
                end
                if (pending_q[k] &&
                    !(owner_active && (owner_q == ID_WIDTH'(k))) &&
                    (wait_cyc_q[k] != '1)) begin
                    wait_cyc_d[k] = wait_cyc_q[k] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= '0;
                wait_cyc_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= grant_cnt_d[k];
                wait_cyc_q[k]  <= wait_cyc_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt_o[k] = grant_cnt_q[k];
            wait_cyc_o[k]  = wait_cyc_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
//   Self-checking bench for mem_req_arbiter with three requesters. Inputs are
//   driven 1 time unit after the rising edge, outputs are sampled 1 unit after
//   that. Expected cache request addresses are queued when a request pulse is
//   driven and popped when cache_req_o.valid appears. The address encodes the
//   requester index in bits [9:8]. Define MEM_ARB_STATS_EN to also cover the
//   statistics counters.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;
    import nmcu_pkg::*;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic            clk;
    logic            rst_n;
    mem_req_t        req_drv  [NREQ];
    mem_resp_t       resp_mon [NREQ];
    mem_req_t        cache_req;
    mem_resp_t       cache_resp;
    logic            busy;
    logic [IDW-1:0]  grant_id;
    logic            err;
    arb_state_t      dbg_state;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]     grant_cnt [NREQ];
    logic [31:0]     wait_cyc  [NREQ];
    logic            stats_clr;
`endif

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [31:0]     exp_q[$];

    mem_req_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_drv),
        .resp_o       (resp_mon),
        .cache_req_o  (cache_req),
        .cache_resp_i (cache_resp),
        .busy_o       (busy),
        .grant_id_o   (grant_id),
        .err_o        (err),
        .dbg_state_o  (dbg_state)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt_o  (grant_cnt),
        .wait_cyc_o   (wait_cyc),
        .stats_clr_i  (stats_clr)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        for (int k = 0; k < NREQ; k++) req_drv[k] = '0;
        cache_resp = '0;
`ifdef MEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    // Advance one cycle; request and response pulses last one cycle only.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int k, input logic [31:0] addr);
        req_drv[k].valid = 1'b1;
        req_drv[k].we    = 1'b0;
        req_drv[k].addr  = addr;
        req_drv[k].wdata = 32'h0;
        req_drv[k].be    = 4'hF;
    endtask

    task automatic respond(input logic [31:0] rdata);
        cache_resp.valid = 1'b1;
        cache_resp.rdata = rdata;
        cache_resp.err   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        pulse(0, 32'h10);
        respond(32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (grant_id !== '0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (cache_req !== '0) begin n_fail++; $display("FAIL reset_cache_req: got %h expected 0", cache_req); end
        n_checks++; if (dbg_state !== ARB_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        for (int k = 0; k < NREQ; k++) begin
            n_checks++; if (resp_mon[k] !== '0) begin n_fail++; $display("FAIL reset_resp%0d: got %h expected 0", k, resp_mon[k]); end
        end
        rst_n = 1'b1;
        clear_inputs();
        repeat (3) tick();
        #1;
        n_checks++; if (cache_req.valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_stale: valid %b busy %b expected 0 0", cache_req.valid, busy); end
    endtask

    task automatic test_single_requester();
        logic [31:0] exp_addr;
        apply_reset();
        pulse(0, 32'h40);
        exp_q.push_back(32'h40);
        #1;
        n_checks++; if (cache_req.valid !== 1'b0) begin n_fail++; $display("FAIL single_t0_valid: got %b expected 0", cache_req.valid); end
        tick(); #1;
        n_checks++; if (cache_req.valid !== 1'b0) begin n_fail++; $display("FAIL single_t1_valid: got %b expected 0", cache_req.valid); end
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL single_t2_issue: valid %b queue %0d expected valid 1", cache_req.valid, exp_q.size());
        end else begin
            exp_addr = exp_q.pop_front();
            if (cache_req.addr !== exp_addr) begin n_fail++; $display("FAIL single_t2_addr: got %h expected %h", cache_req.addr, exp_addr); end
        end
        n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_t2_grant: grant %0d busy %b expected 0 1", grant_id, busy); end
        tick(); #1;
        n_checks++; if (cache_req.valid !== 1'b0) begin n_fail++; $display("FAIL single_t3_valid: got %b expected 0", cache_req.valid); end
        tick();
        tick();
        respond(32'h1234);
        #1;
        n_checks++; if (resp_mon[0].valid !== 1'b1 || resp_mon[0].rdata !== 32'h1234) begin n_fail++; $display("FAIL single_resp0: got %b/%h expected 1/1234", resp_mon[0].valid, resp_mon[0].rdata); end
        n_checks++; if (resp_mon[1] !== '0 || resp_mon[2] !== '0) begin n_fail++; $display("FAIL single_resp_other: got %h %h expected 0", resp_mon[1], resp_mon[2]); end
        tick(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_t6_busy: got %b expected 0", busy); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_addr;
        apply_reset();
        pulse(0, 32'h500);
        pulse(1, 32'h600);
        exp_q.push_back(32'h500);
        exp_q.push_back(32'h600);
        tick();
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL simul_first_issue: valid %b expected 1", cache_req.valid);
        end else begin
            exp_addr = exp_q.pop_front();
            if (cache_req.addr !== exp_addr || grant_id !== 2'd0) begin n_fail++; $display("FAIL simul_first: addr %h grant %0d expected %h 0", cache_req.addr, grant_id, exp_addr); end
        end
        tick();
        tick();
        respond(32'hBEEF);
        #1;
        n_checks++; if (resp_mon[0].rdata !== 32'hBEEF || resp_mon[1] !== '0) begin n_fail++; $display("FAIL simul_resp0: r0 %h r1 %h expected beef 0", resp_mon[0].rdata, resp_mon[1]); end
        tick(); #1;
        n_checks++; if (cache_req.valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle_gap: valid %b busy %b expected 0 0", cache_req.valid, busy); end
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL simul_second_issue: valid %b expected 1", cache_req.valid);
        end else begin
            exp_addr = exp_q.pop_front();
            if (cache_req.addr !== exp_addr || grant_id !== 2'd1) begin n_fail++; $display("FAIL simul_second: addr %h grant %0d expected %h 1", cache_req.addr, grant_id, exp_addr); end
        end
        tick();
        respond(32'hCAFE);
        #1;
        n_checks++; if (resp_mon[1].rdata !== 32'hCAFE || resp_mon[0] !== '0) begin n_fail++; $display("FAIL simul_resp1: r1 %h r0 %h expected cafe 0", resp_mon[1].rdata, resp_mon[0]); end
    endtask

    task automatic test_round_robin();
        int          issued, responded, cyc, resp_cnt, cur_owner, repulse_k, pulses;
        logic        resp_now, other_bad;
        logic [31:0] cur_addr, exp_addr;
        logic [31:0] seq_addr [NREQ];
        apply_reset();
        for (int k = 0; k < NREQ; k++) begin
            seq_addr[k] = 32'h1000 + 32'(k) * 32'h100;
            pulse(k, seq_addr[k]);
            exp_q.push_back(seq_addr[k]);
        end
        pulses = NREQ; issued = 0; responded = 0; cyc = 0;
        resp_cnt = 0; repulse_k = -1; cur_owner = 0; cur_addr = '0;
        while (responded < 9 && cyc < 300) begin
            tick();
            cyc++;
            if (repulse_k >= 0) begin
                seq_addr[repulse_k] = seq_addr[repulse_k] + 32'h4;
                pulse(repulse_k, seq_addr[repulse_k]);
                exp_q.push_back(seq_addr[repulse_k]);
                pulses++;
                repulse_k = -1;
            end
            resp_now = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    respond(cur_addr ^ 32'hA5A5_0000);
                    resp_now = 1'b1;
                end
            end
            #1;
            if (cache_req.valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rr_unexpected_issue: addr %h with empty queue", cache_req.addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    if (cache_req.addr !== exp_addr) begin n_fail++; $display("FAIL rr_addr: got %h expected %h", cache_req.addr, exp_addr); end
                    cur_owner = int'(exp_addr[9:8]);
                    cur_addr  = exp_addr;
                end
                n_checks++; if (grant_id !== IDW'(issued % NREQ)) begin n_fail++; $display("FAIL rr_order: txn %0d grant %0d expected %0d", issued, grant_id, issued % NREQ); end
                resp_cnt = $urandom_range(1, 3);
                issued++;
            end
            if (resp_now) begin
                other_bad = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (k != cur_owner && resp_mon[k] !== '0) other_bad = 1'b1;
                end
                n_checks++; if (resp_mon[cur_owner].rdata !== (cur_addr ^ 32'hA5A5_0000) || resp_mon[cur_owner].valid !== 1'b1 || other_bad) begin
                    n_fail++; $display("FAIL rr_resp: owner %0d got %h expected %h other_bad %b", cur_owner, resp_mon[cur_owner].rdata, cur_addr ^ 32'hA5A5_0000, other_bad);
                end
                responded++;
                if (pulses < 9) repulse_k = cur_owner;
            end
        end
        n_checks++; if (responded != 9) begin n_fail++; $display("FAIL rr_timeout: got %0d responses expected 9", responded); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b expected 0", err); end
    endtask

    task automatic test_violation_double_pulse();
        int          extra;
        logic [31:0] exp_addr;
        apply_reset();
        pulse(0, 32'h700);
        exp_q.push_back(32'h700);
        tick();
        pulse(1, 32'h710);
        exp_q.push_back(32'h710);
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dbl_err_early: got %b expected 0", err); end
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL dbl_issue0: valid %b expected 1", cache_req.valid); end
        else begin exp_addr = exp_q.pop_front(); if (cache_req.addr !== exp_addr) begin n_fail++; $display("FAIL dbl_addr0: got %h expected %h", cache_req.addr, exp_addr); end end
        tick();
        pulse(1, 32'h7F0);
        tick(); #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL dbl_err_set: got %b expected 1", err); end
        tick();
        respond(32'h1);
        tick();
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL dbl_issue1: valid %b expected 1", cache_req.valid); end
        else begin exp_addr = exp_q.pop_front(); if (cache_req.addr !== exp_addr || grant_id !== 2'd1) begin n_fail++; $display("FAIL dbl_addr1: got %h grant %0d expected %h 1", cache_req.addr, grant_id, exp_addr); end end
        tick();
        respond(32'h2);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            tick(); #1;
            if (cache_req.valid === 1'b1) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL dbl_extra_issue: got %0d extra requests expected 0", extra); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL dbl_err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_violation_release_cycle();
        int          extra;
        logic [31:0] exp_addr;
        apply_reset();
        pulse(0, 32'h800);
        exp_q.push_back(32'h800);
        tick();
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL rel_issue0: valid %b expected 1", cache_req.valid); end
        else begin exp_addr = exp_q.pop_front(); if (cache_req.addr !== exp_addr) begin n_fail++; $display("FAIL rel_addr0: got %h expected %h", cache_req.addr, exp_addr); end end
        tick();
        tick();
        // Release cycle: owner re-pulse must be dropped, non-owner captured.
        respond(32'h3);
        pulse(0, 32'h8F0);
        pulse(1, 32'h910);
        exp_q.push_back(32'h910);
        tick(); #1;
        n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rel_err: err %b busy %b expected 1 0", err, busy); end
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL rel_issue1: valid %b expected 1", cache_req.valid); end
        else begin exp_addr = exp_q.pop_front(); if (cache_req.addr !== exp_addr || grant_id !== 2'd1) begin n_fail++; $display("FAIL rel_addr1: got %h grant %0d expected %h 1", cache_req.addr, grant_id, exp_addr); end end
        tick();
        respond(32'h4);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            if (cache_req.valid === 1'b1) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL rel_extra_issue: got %0d expected 0", extra); end
    endtask

    task automatic test_resp_in_issue();
        logic [31:0] exp_addr;
        apply_reset();
        pulse(0, 32'hA00);
        exp_q.push_back(32'hA00);
        tick();
        tick();
        respond(32'hDEAD);
        #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL early_issue: valid %b expected 1", cache_req.valid); end
        else begin exp_addr = exp_q.pop_front(); if (cache_req.addr !== exp_addr) begin n_fail++; $display("FAIL early_addr: got %h expected %h", cache_req.addr, exp_addr); end end
        n_checks++; if (resp_mon[0] !== '0 || resp_mon[1] !== '0 || resp_mon[2] !== '0) begin n_fail++; $display("FAIL early_resp_forwarded: got %h %h %h expected 0", resp_mon[0], resp_mon[1], resp_mon[2]); end
        tick(); #1;
        n_checks++; if (dbg_state !== ARB_WAIT || busy !== 1'b1) begin n_fail++; $display("FAIL early_still_wait: state %0d busy %b expected 2 1", dbg_state, busy); end
        tick();
        respond(32'hF00D);
        #1;
        n_checks++; if (resp_mon[0].rdata !== 32'hF00D || resp_mon[0].valid !== 1'b1) begin n_fail++; $display("FAIL early_real_resp: got %h expected f00d", resp_mon[0].rdata); end
    endtask

    task automatic test_reset_mid_operation();
        int          extra;
        logic [31:0] exp_addr;
        apply_reset();
        pulse(0, 32'hB00);
        pulse(1, 32'hB10);
        exp_q.push_back(32'hB00);
        tick();
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL mid_issue0: valid %b expected 1", cache_req.valid); end
        else begin exp_addr = exp_q.pop_front(); if (cache_req.addr !== exp_addr) begin n_fail++; $display("FAIL mid_addr0: got %h expected %h", cache_req.addr, exp_addr); end end
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || cache_req !== '0 || grant_id !== '0 || err !== 1'b0 || dbg_state !== ARB_IDLE) begin
            n_fail++; $display("FAIL mid_reset_outputs: busy %b req %h grant %0d err %b state %0d expected all 0", busy, cache_req, grant_id, err, dbg_state);
        end
        tick();
        rst_n = 1'b1;
        respond(32'h5555);
        #1;
        n_checks++; if (resp_mon[0] !== '0 || resp_mon[1] !== '0 || resp_mon[2] !== '0) begin n_fail++; $display("FAIL mid_late_resp: got %h %h %h expected 0", resp_mon[0], resp_mon[1], resp_mon[2]); end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            if (cache_req.valid === 1'b1) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL mid_discarded_slot: got %0d requests expected 0", extra); end
        pulse(2, 32'hC20);
        exp_q.push_back(32'hC20);
        tick();
        tick(); #1;
        n_checks++;
        if (cache_req.valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL mid_issue2: valid %b expected 1", cache_req.valid); end
        else begin exp_addr = exp_q.pop_front(); if (cache_req.addr !== exp_addr || grant_id !== 2'd2) begin n_fail++; $display("FAIL mid_addr2: got %h grant %0d expected %h 2", cache_req.addr, grant_id, exp_addr); end end
        tick();
        respond(32'h7777);
        #1;
        n_checks++; if (resp_mon[2].rdata !== 32'h7777 || resp_mon[2].valid !== 1'b1) begin n_fail++; $display("FAIL mid_resp2: got %h expected 7777", resp_mon[2].rdata); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_queue_left: got %0d entries expected 0", exp_q.size()); end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        int k;
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            k = (j < 3) ? 0 : 1;
            pulse(k, 32'hD00 + 32'(k) * 32'h100 + 32'(j));
            tick();
            tick(); #1;
            n_checks++; if (cache_req.valid !== 1'b1 || grant_id !== IDW'(k)) begin n_fail++; $display("FAIL stats_issue%0d: valid %b grant %0d expected 1 %0d", j, cache_req.valid, grant_id, k); end
            tick();
            respond(32'(j));
            tick();
        end
        #1;
        n_checks++; if (grant_cnt[0] !== 32'd3 || grant_cnt[1] !== 32'd1 || grant_cnt[2] !== 32'd0) begin
            n_fail++; $display("FAIL stats_grant_cnt: got %0d %0d %0d expected 3 1 0", grant_cnt[0], grant_cnt[1], grant_cnt[2]);
        end
        n_checks++; if (wait_cyc[0] !== 32'd3 || wait_cyc[1] !== 32'd1 || wait_cyc[2] !== 32'd0) begin
            n_fail++; $display("FAIL stats_wait_cyc: got %0d %0d %0d expected 3 1 0", wait_cyc[0], wait_cyc[1], wait_cyc[2]);
        end
        stats_clr = 1'b1;
        tick(); #1;
        for (int i = 0; i < NREQ; i++) begin
            n_checks++; if (grant_cnt[i] !== 32'd0 || wait_cyc[i] !== 32'd0) begin n_fail++; $display("FAIL stats_clear%0d: got %0d %0d expected 0 0", i, grant_cnt[i], wait_cyc[i]); end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_requester();
        test_simultaneous();
        test_round_robin();
        test_violation_double_pulse();
        test_violation_release_cycle();
        test_resp_in_issue();
        test_reset_mid_operation();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
